// File: rtl/cpu_pkg.sv
// Shared field map and opcode constants for the 16-bit processor decode stage.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RA_MSB    = 11;
  localparam int RA_LSB    = 8;
  localparam int RB_MSB    = 7;
  localparam int RB_LSB    = 4;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return (instr[OP_MSB:OP_LSB] == OP_HALT);
  endfunction

endpackage

// File: rtl/decode_skid_entry.sv
// One {pc, instr} holding register with a valid flag; load has priority over clear.
module decode_skid_entry #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d_pc,
  input  logic [W-1:0] d_instr,
  output logic         valid,
  output logic [W-1:0] pc,
  output logic [W-1:0] instr
);

  logic         valid_q, valid_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] instr_q, instr_d;

  // Next-state: data only changes on load, so a cleared entry keeps its last contents.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (load) begin
      valid_d = 1'b1;
      pc_d    = d_pc;
      instr_d = d_instr;
    end else if (clear) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= {W{1'b0}};
      instr_q <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/instr_decode_latch.sv
// Decode-stage input register: valid/ready latch, field split, HALT detect, retire count.
// Define SKID_BUFFER_EN for a second (skid) entry and a registered in_ready.
module instr_decode_latch
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [3:0]        out_ra,
  output logic [3:0]        out_rb,
  output logic [3:0]        out_funct,
  output logic [7:0]        out_imm8,
  output logic [DATA_W-1:0] out_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  logic              accept_s;
  logic              retire_s;
  logic              out_free_s;
  logic              out_load_s;
  logic              out_clear_s;
  logic [DATA_W-1:0] out_d_pc_s;
  logic [DATA_W-1:0] out_d_instr_s;
  logic              out_v_s;
  logic [DATA_W-1:0] out_pc_s;
  logic [DATA_W-1:0] out_instr_s;

  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign retire_s   = out_v_s && out_ready;
  assign accept_s   = in_valid && in_ready;
  assign out_free_s = !out_v_s || out_ready;

  decode_skid_entry #(.W(DATA_W)) u_out_entry (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (out_load_s),
    .clear   (out_clear_s),
    .d_pc    (out_d_pc_s),
    .d_instr (out_d_instr_s),
    .valid   (out_v_s),
    .pc      (out_pc_s),
    .instr   (out_instr_s)
  );

`ifdef SKID_BUFFER_EN
  logic              skid_load_s;
  logic              skid_clear_s;
  logic              skid_v_s;
  logic              skid_v_nxt_s;
  logic [DATA_W-1:0] skid_pc_s;
  logic [DATA_W-1:0] skid_instr_s;
  logic              in_ready_q, in_ready_d;

  decode_skid_entry #(.W(DATA_W)) u_skid_entry (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load_s),
    .clear   (skid_clear_s),
    .d_pc    (in_pc),
    .d_instr (in_instr),
    .valid   (skid_v_s),
    .pc      (skid_pc_s),
    .instr   (skid_instr_s)
  );

  // Skid drains into the output first; a new word goes to skid if output is stalled or skid is draining.
  always_comb begin
    out_load_s    = !flush && out_free_s && (skid_v_s || accept_s);
    out_d_pc_s    = skid_v_s ? skid_pc_s : in_pc;
    out_d_instr_s = skid_v_s ? skid_instr_s : in_instr;
    out_clear_s   = flush || (retire_s && !skid_v_s && !accept_s);
    skid_load_s   = !flush && accept_s && (!out_free_s || skid_v_s);
    skid_clear_s  = flush || (out_free_s && skid_v_s && !accept_s);
    if (skid_load_s) begin
      skid_v_nxt_s = 1'b1;
    end else if (skid_clear_s) begin
      skid_v_nxt_s = 1'b0;
    end else begin
      skid_v_nxt_s = skid_v_s;
    end
    in_ready_d = !skid_v_nxt_s && !halted_d;
  end

  // Registered ready; resets low so fetch sees ready from the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
`else
  logic rdy_en_q;

  // Holds ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  assign in_ready = rdy_en_q && !halted_q && out_free_s;

  // Single entry: a new word can only land when the output is empty or retiring.
  always_comb begin
    out_load_s    = accept_s && !flush;
    out_d_pc_s    = in_pc;
    out_d_instr_s = in_instr;
    out_clear_s   = flush || (retire_s && !accept_s);
  end
`endif

  // A flushed retire is neither counted nor allowed to set halted.
  always_comb begin
    if (retire_s && !flush) begin
      cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      halted_d = halted_q || is_halt(out_instr_s);
    end else begin
      cnt_d    = cnt_q;
      halted_d = halted_q;
    end
  end

  // Sticky halt flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = out_v_s;
  assign out_pc      = out_pc_s;
  assign out_op      = out_instr_s[OP_MSB:OP_LSB];
  assign out_ra      = out_instr_s[RA_MSB:RA_LSB];
  assign out_rb      = out_instr_s[RB_MSB:RB_LSB];
  assign out_funct   = out_instr_s[FUNCT_MSB:FUNCT_LSB];
  assign out_imm8    = out_instr_s[IMM_MSB:IMM_LSB];
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule
